// File: rtl/csi2_packet_decoder_if.sv
// ---------------------------------------------------------------------------
// csi2_packet_decoder_if
//
// Byte-stream bundle between the MIPI lane receiver, the CSI-2 packet decoder
// and the pixel pipeline.
//
//   in_valid   receiver -> decoder  in_data holds a valid HS byte
//   in_data    receiver -> decoder  byte in packet order
//   in_sot     receiver -> decoder  with in_valid: first byte after sync word
//   in_eot     receiver -> decoder  single-cycle pulse: receiver left HS mode
//   pix_valid  decoder  -> pipeline forwarded payload byte valid
//   pix_data   decoder  -> pipeline payload byte
//   pix_first  decoder  -> pipeline first payload byte of the packet
//   pix_last   decoder  -> pipeline last payload byte of the packet
//
// master: the side that feeds bytes in and watches pixels come out.
// slave : the decoder itself.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

interface csi2_packet_decoder_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_sot;
    logic       in_eot;
    logic       pix_valid;
    logic [7:0] pix_data;
    logic       pix_first;
    logic       pix_last;

    modport master (
        output in_valid, in_data, in_sot, in_eot,
        input  pix_valid, pix_data, pix_first, pix_last
    );

    modport slave (
        input  in_valid, in_data, in_sot, in_eot,
        output pix_valid, pix_data, pix_first, pix_last
    );
endinterface

// File: rtl/csi2_packet_decoder.sv
// ---------------------------------------------------------------------------
// csi2_packet_decoder
//
// Parses the lane-merged CSI-2 HS byte stream: 4-byte packet header with
// Hamming ECC check, long-packet payload and trailing CRC-16. Emits frame and
// line markers, and forwards the payload of one selected data type.
//
// Ports
//   sys_clk      system clock
//   reset        asynchronous active-low reset
//   bus          csi2_packet_decoder_if.slave (in_* byte stream, pix_* out)
//   frame_start  pulse on a good FS short packet (DT 0x00)
//   frame_end    pulse on a good FE short packet (DT 0x01)
//   line_start   pulse on a good LS short packet (DT 0x02)
//   line_end     pulse on a good LE short packet (DT 0x03)
//   data_type    DT of the last accepted header
//   word_count   WC of the last accepted header
//   line_count   DT_SELECT long packets completed since the last frame_start
//   packet_done  pulse when a long packet finishes (after its CRC)
//   ecc_err      pulse: header ECC mismatch or oversize word count
//   crc_err      pulse: payload CRC mismatch
//   trunc_err    pulse: packet aborted by in_eot or an early in_sot
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module csi2_packet_decoder #(
    parameter logic [5:0] DT_SELECT = 6'h2A,
    parameter int         MAX_WC    = 4096,
    parameter int         WC_W      = 16
) (
    input  logic                  sys_clk,
    input  logic                  reset,
    csi2_packet_decoder_if.slave  bus,
    output logic                  frame_start,
    output logic                  frame_end,
    output logic                  line_start,
    output logic                  line_end,
    output logic [5:0]            data_type,
    output logic [WC_W-1:0]       word_count,
    output logic [WC_W-1:0]       line_count,
    output logic                  packet_done,
    output logic                  ecc_err,
    output logic                  crc_err,
    output logic                  trunc_err
);

    typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, CRC} state_t;

    localparam logic [16:0] MAX_WC_L = 17'(MAX_WC);

    state_t      state, state_nxt;
    logic [1:0]  hdr_cnt;
    logic [7:0]  hdr_b0, hdr_b1, hdr_b2;
    logic [15:0] rem_cnt;
    logic        first_pend;
    logic        sel_pkt;
    logic        crc_cnt;
    logic [7:0]  crc_lo;
    logic [15:0] crc_run;

    logic        sot_byte, data_byte;
    logic [5:0]  hdr_dt;
    logic [15:0] hdr_wc;
    logic        ecc_ok;

    logic        start_hdr, hdr_ok, line_inc;
    logic        fs_d, fe_d, ls_d, le_d;
    logic        ecc_err_d, crc_err_d, done_d, trunc_d;
    logic        pix_valid_d, pix_first_d, pix_last_d;

    // CSI-2 6-bit Hamming parity over {WC, DI}; d[0] is DI bit 0.
    function automatic logic [5:0] ecc6(input logic [23:0] d);
        logic [5:0] p;
        p[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
        p[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
        p[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]^d[20]^d[21]^d[22];
        p[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]^d[20]^d[21]^d[23];
        p[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]^d[19]^d[20]^d[22]^d[23];
        p[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]^d[18]^d[19]^d[21]^d[22]^d[23];
        return p;
    endfunction

    // Reflected CCITT CRC (0x8408), one byte, data taken LSB first.
    function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ d[i])
                r = (r >> 1) ^ 16'h8408;
            else
                r = r >> 1;
        end
        return r;
    endfunction

    assign sot_byte  = bus.in_valid & bus.in_sot;
    assign data_byte = bus.in_valid & ~bus.in_sot;
    assign hdr_dt    = hdr_b0[5:0];
    assign hdr_wc    = {hdr_b2, hdr_b1};
    // The ECC byte is the one arriving now; its top two bits must be zero.
    assign ecc_ok    = (bus.in_data[7:6] == 2'b00) &&
                       (bus.in_data[5:0] == ecc6({hdr_wc, hdr_b0}));

    // FSM state register
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state and per-cycle event decode. A byte arriving together with
    // in_eot is processed first; the abort then applies only if that byte
    // left the packet unfinished, so a packet completed by it reports
    // normally and a payload byte cut off by it never carries pix_last.
    always_comb begin
        state_nxt   = state;
        start_hdr   = 1'b0;
        hdr_ok      = 1'b0;
        line_inc    = 1'b0;
        fs_d        = 1'b0;
        fe_d        = 1'b0;
        ls_d        = 1'b0;
        le_d        = 1'b0;
        ecc_err_d   = 1'b0;
        crc_err_d   = 1'b0;
        done_d      = 1'b0;
        trunc_d     = 1'b0;
        pix_valid_d = 1'b0;
        pix_first_d = 1'b0;
        pix_last_d  = 1'b0;

        if (sot_byte) begin
            if (state != IDLE)
                trunc_d = 1'b1;
            start_hdr = 1'b1;
            state_nxt = HDR;
        end else if (data_byte) begin
            case (state)
                HDR: begin
                    if (hdr_cnt == 2'd3) begin
                        state_nxt = IDLE;
                        if (!ecc_ok) begin
                            ecc_err_d = 1'b1;
                        end else if (hdr_dt <= 6'h0F) begin
                            hdr_ok = 1'b1;
                            fs_d   = (hdr_dt == 6'h00);
                            fe_d   = (hdr_dt == 6'h01);
                            ls_d   = (hdr_dt == 6'h02);
                            le_d   = (hdr_dt == 6'h03);
                        end else if ({1'b0, hdr_wc} > MAX_WC_L) begin
                            ecc_err_d = 1'b1;
                        end else begin
                            hdr_ok    = 1'b1;
                            state_nxt = (hdr_wc == 16'd0) ? CRC : PAYLOAD;
                        end
                    end
                end
                PAYLOAD: begin
                    pix_valid_d = sel_pkt;
                    pix_first_d = sel_pkt & first_pend;
                    pix_last_d  = sel_pkt & (rem_cnt == 16'd1);
                    if (rem_cnt == 16'd1)
                        state_nxt = CRC;
                end
                CRC: begin
                    if (crc_cnt) begin
                        state_nxt = IDLE;
                        done_d    = 1'b1;
                        crc_err_d = ({bus.in_data, crc_lo} != crc_run);
                        line_inc  = sel_pkt;
                    end
                end
                default: ;
            endcase
        end

        if (bus.in_eot && (state_nxt != IDLE)) begin
            trunc_d    = 1'b1;
            state_nxt  = IDLE;
            pix_last_d = 1'b0;
        end
    end

    // Header capture, payload countdown and running CRC
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            hdr_cnt    <= 2'd0;
            hdr_b0     <= 8'd0;
            hdr_b1     <= 8'd0;
            hdr_b2     <= 8'd0;
            rem_cnt    <= 16'd0;
            first_pend <= 1'b0;
            sel_pkt    <= 1'b0;
            crc_cnt    <= 1'b0;
            crc_lo     <= 8'd0;
            crc_run    <= 16'hFFFF;
        end else begin
            if (start_hdr) begin
                hdr_cnt <= 2'd1;
                hdr_b0  <= bus.in_data;
            end else if (data_byte && state == HDR) begin
                hdr_cnt <= hdr_cnt + 2'd1;
                if (hdr_cnt == 2'd1)
                    hdr_b1 <= bus.in_data;
                if (hdr_cnt == 2'd2)
                    hdr_b2 <= bus.in_data;
            end

            if (hdr_ok) begin
                rem_cnt    <= hdr_wc;
                first_pend <= 1'b1;
                sel_pkt    <= (hdr_dt == DT_SELECT);
                crc_cnt    <= 1'b0;
                crc_run    <= 16'hFFFF;
            end else if (data_byte && state == PAYLOAD) begin
                rem_cnt    <= rem_cnt - 16'd1;
                first_pend <= 1'b0;
                crc_run    <= crc16_byte(crc_run, bus.in_data);
            end else if (data_byte && state == CRC) begin
                crc_cnt <= 1'b1;
                crc_lo  <= bus.in_data;
            end
        end
    end

    // Registered outputs: every pulse lands one cycle after the byte that
    // caused it. frame_start and the line_count clear share the same cycle.
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            frame_start   <= 1'b0;
            frame_end     <= 1'b0;
            line_start    <= 1'b0;
            line_end      <= 1'b0;
            ecc_err       <= 1'b0;
            crc_err       <= 1'b0;
            packet_done   <= 1'b0;
            trunc_err     <= 1'b0;
            data_type     <= 6'd0;
            word_count    <= '0;
            line_count    <= '0;
            bus.pix_valid <= 1'b0;
            bus.pix_data  <= 8'd0;
            bus.pix_first <= 1'b0;
            bus.pix_last  <= 1'b0;
        end else begin
            frame_start   <= fs_d;
            frame_end     <= fe_d;
            line_start    <= ls_d;
            line_end      <= le_d;
            ecc_err       <= ecc_err_d;
            crc_err       <= crc_err_d;
            packet_done   <= done_d;
            trunc_err     <= trunc_d;
            bus.pix_valid <= pix_valid_d;
            bus.pix_data  <= bus.in_data;
            bus.pix_first <= pix_first_d;
            bus.pix_last  <= pix_last_d;
            if (hdr_ok) begin
                data_type  <= hdr_dt;
                word_count <= WC_W'(hdr_wc);
            end
            if (fs_d)
                line_count <= '0;
            else if (line_inc)
                line_count <= line_count + WC_W'(1);
        end
    end

endmodule

// File: tb/tb_csi2_packet_decoder.sv
// ---------------------------------------------------------------------------
// tb_csi2_packet_decoder
//
// Directed bench for csi2_packet_decoder: a table of packets with expected
// marker/error pulse counts, forwarded bytes and header registers, followed
// by hand-written sequences for cycle timing, in_eot coinciding with the
// final CRC byte, and an early-sot abort.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_csi2_packet_decoder;

    logic        sys_clk;
    logic        reset;
    logic        frame_start, frame_end, line_start, line_end;
    logic [5:0]  data_type;
    logic [15:0] word_count, line_count;
    logic        packet_done, ecc_err, crc_err, trunc_err;

    int checks   = 0;
    int failures = 0;

    csi2_packet_decoder_if bus();

    csi2_packet_decoder #(
        .DT_SELECT (6'h2A),
        .MAX_WC    (4096),
        .WC_W      (16)
    ) dut (
        .sys_clk     (sys_clk),
        .reset       (reset),
        .bus         (bus),
        .frame_start (frame_start),
        .frame_end   (frame_end),
        .line_start  (line_start),
        .line_end    (line_end),
        .data_type   (data_type),
        .word_count  (word_count),
        .line_count  (line_count),
        .packet_done (packet_done),
        .ecc_err     (ecc_err),
        .crc_err     (crc_err),
        .trunc_err   (trunc_err)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Known CSI-2 payload whose CRC-16 is 0x00F0.
    logic [7:0] known_tbl [24] = '{
        8'hFF, 8'h00, 8'h00, 8'h02, 8'hB9, 8'hDC, 8'hF3, 8'h72,
        8'hBB, 8'hD4, 8'hB8, 8'h5A, 8'hC8, 8'h75, 8'hC2, 8'h7C,
        8'h81, 8'hF8, 8'h05, 8'hDF, 8'hFF, 8'h00, 8'h00, 8'h01
    };

    typedef struct {
        logic [7:0]  di;
        logic [15:0] wc;
        logic [7:0]  ecc_xor;
        logic        body;
        logic [7:0]  seed;
        logic        known;
        logic        gaps;
        logic        trunc;
        int          ntrunc;
        logic [15:0] crc_xor;
        logic        crc_lit_en;
        logic [15:0] crc_lit;
        int          e_fs, e_fe, e_ls, e_le;
        int          e_ecc, e_crc, e_trunc, e_done;
        int          e_npix, e_last, e_lc;
        logic [5:0]  e_dt;
        logic [15:0] e_wc;
    } vec_t;

    localparam int NVEC = 18;
    vec_t tbl [NVEC];

    // Monitor state: running totals, never cleared; vectors compare deltas.
    int         cnt_fs = 0, cnt_fe = 0, cnt_ls = 0, cnt_le = 0;
    int         cnt_ecc = 0, cnt_crc = 0, cnt_trunc = 0, cnt_done = 0;
    int         cnt_first = 0, cnt_last = 0;
    int         first_idx = -1, last_idx = -1;
    logic [7:0] pix_q [$];

    always @(negedge sys_clk) begin
        if (reset) begin
            if (frame_start) cnt_fs++;
            if (frame_end)   cnt_fe++;
            if (line_start)  cnt_ls++;
            if (line_end)    cnt_le++;
            if (ecc_err)     cnt_ecc++;
            if (crc_err)     cnt_crc++;
            if (trunc_err)   cnt_trunc++;
            if (packet_done) cnt_done++;
            if (bus.pix_valid) begin
                if (bus.pix_first) begin
                    cnt_first++;
                    first_idx = pix_q.size();
                end
                if (bus.pix_last) begin
                    cnt_last++;
                    last_idx = pix_q.size();
                end
                pix_q.push_back(bus.pix_data);
            end
        end
    end

    initial begin
        #1ms;
        $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    // Bench reference ECC: one XOR mask per parity bit over {WC, DI}.
    function automatic logic [7:0] ecc_model(input logic [23:0] d);
        logic [23:0] m [6];
        logic [7:0]  p;
        m[0] = 24'hF12CB7;
        m[1] = 24'hF2555B;
        m[2] = 24'h749A6D;
        m[3] = 24'hB8E38E;
        m[4] = 24'hDF03F0;
        m[5] = 24'hEFFC00;
        p = 8'h00;
        for (int k = 0; k < 6; k++)
            p[k] = ^(d & m[k]);
        return p;
    endfunction

    // Bench reference CRC-16/X.25 step without final XOR, bit-serial.
    function automatic logic [15:0] crc_model(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        logic        fb;
        r = c;
        for (int i = 0; i < 8; i++) begin
            fb = r[0] ^ d[i];
            r  = {1'b0, r[15:1]};
            if (fb)
                r = r ^ 16'h8408;
        end
        return r;
    endfunction

    function automatic logic [7:0] pay_byte(input vec_t v, input int i);
        if (v.known)
            return known_tbl[i];
        return v.seed + 8'(i * 17);
    endfunction

    function automatic vec_t hdr_vec(input logic [7:0] di, input logic [15:0] wc,
                                     input logic [7:0] ecc_xor);
        vec_t v;
        v = '{di: di, wc: wc, ecc_xor: ecc_xor, body: 1'b0, seed: 8'h00, known: 1'b0,
              gaps: 1'b0, trunc: 1'b0, ntrunc: 0, crc_xor: 16'h0000, crc_lit_en: 1'b0,
              crc_lit: 16'h0000, e_fs: 0, e_fe: 0, e_ls: 0, e_le: 0, e_ecc: 0, e_crc: 0,
              e_trunc: 0, e_done: 0, e_npix: 0, e_last: 0, e_lc: 0, e_dt: 6'h00,
              e_wc: 16'h0000};
        return v;
    endfunction

    function automatic vec_t long_vec(input logic [7:0] di, input logic [15:0] wc,
                                      input logic [7:0] seed);
        vec_t v;
        v      = hdr_vec(di, wc, 8'h00);
        v.body = 1'b1;
        v.seed = seed;
        return v;
    endfunction

    function automatic vec_t with_exp(input vec_t v,
                                      input int fs, input int fe, input int ls, input int le,
                                      input int ecc, input int crc, input int tr, input int done,
                                      input int npix, input int last, input int lc,
                                      input logic [5:0] dt, input logic [15:0] wc);
        vec_t r;
        r = v;
        r.e_fs = fs;   r.e_fe = fe;     r.e_ls = ls;     r.e_le = le;
        r.e_ecc = ecc; r.e_crc = crc;   r.e_trunc = tr;  r.e_done = done;
        r.e_npix = npix; r.e_last = last; r.e_lc = lc;
        r.e_dt = dt;   r.e_wc = wc;
        return r;
    endfunction

    task automatic check_val(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("[TB] FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic sot, input logic eot,
                             input logic gap);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_sot   = sot;
        bus.in_eot   = eot;
        @(posedge sys_clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        bus.in_sot   = 1'b0;
        bus.in_eot   = 1'b0;
        if (gap)
            idle_cycles(1);
    endtask

    task automatic send_eot();
        bus.in_eot = 1'b1;
        @(posedge sys_clk);
        #1;
        bus.in_eot = 1'b0;
    endtask

    task automatic send_header(input logic [7:0] di, input logic [15:0] wc,
                               input logic [7:0] ecc_xor, input logic gap);
        logic [7:0] e;
        e = ecc_model({wc, di}) ^ ecc_xor;
        send_byte(di,        1'b1, 1'b0, gap);
        send_byte(wc[7:0],   1'b0, 1'b0, gap);
        send_byte(wc[15:8],  1'b0, 1'b0, gap);
        send_byte(e,         1'b0, 1'b0, gap);
    endtask

    task automatic apply_stimulus(input vec_t v);
        logic [15:0] crc;
        logic [15:0] crc_tx;
        logic [7:0]  b;
        int          n;
        send_header(v.di, v.wc, v.ecc_xor, v.gaps);
        if (v.body) begin
            crc = 16'hFFFF;
            n   = v.trunc ? v.ntrunc : int'(v.wc);
            for (int i = 0; i < n; i++) begin
                b   = pay_byte(v, i);
                crc = crc_model(crc, b);
                send_byte(b, 1'b0, 1'b0, v.gaps);
            end
            if (v.trunc) begin
                send_eot();
            end else begin
                crc_tx = v.crc_lit_en ? v.crc_lit : (crc ^ v.crc_xor);
                send_byte(crc_tx[7:0],  1'b0, 1'b0, v.gaps);
                send_byte(crc_tx[15:8], 1'b0, 1'b0, v.gaps);
            end
        end
        idle_cycles(3);
    endtask

    task automatic check_output(input int id, input vec_t v,
                                input int b_fs, input int b_fe, input int b_ls, input int b_le,
                                input int b_ecc, input int b_crc, input int b_tr, input int b_done,
                                input int b_first, input int b_last, input int b_pix);
        int npix;
        check_val($sformatf("v%0d.frame_start", id), cnt_fs - b_fs,       v.e_fs);
        check_val($sformatf("v%0d.frame_end", id),   cnt_fe - b_fe,       v.e_fe);
        check_val($sformatf("v%0d.line_start", id),  cnt_ls - b_ls,       v.e_ls);
        check_val($sformatf("v%0d.line_end", id),    cnt_le - b_le,       v.e_le);
        check_val($sformatf("v%0d.ecc_err", id),     cnt_ecc - b_ecc,     v.e_ecc);
        check_val($sformatf("v%0d.crc_err", id),     cnt_crc - b_crc,     v.e_crc);
        check_val($sformatf("v%0d.trunc_err", id),   cnt_trunc - b_tr,    v.e_trunc);
        check_val($sformatf("v%0d.packet_done", id), cnt_done - b_done,   v.e_done);
        npix = pix_q.size() - b_pix;
        check_val($sformatf("v%0d.pix_count", id),   npix,                v.e_npix);
        check_val($sformatf("v%0d.pix_first", id),   cnt_first - b_first, (v.e_npix > 0) ? 1 : 0);
        if (v.e_npix > 0)
            check_val($sformatf("v%0d.pix_first_pos", id), first_idx - b_pix, 0);
        check_val($sformatf("v%0d.pix_last", id),    cnt_last - b_last,   v.e_last);
        if (v.e_last > 0)
            check_val($sformatf("v%0d.pix_last_pos", id), last_idx - b_pix, v.e_npix - 1);
        for (int i = 0; i < v.e_npix && i < npix; i++)
            check_val($sformatf("v%0d.pix_data[%0d]", id, i),
                      int'(pix_q[b_pix + i]), int'(pay_byte(v, i)));
        check_val($sformatf("v%0d.line_count", id),  int'(line_count),    v.e_lc);
        check_val($sformatf("v%0d.data_type", id),   int'(data_type),     int'(v.e_dt));
        check_val($sformatf("v%0d.word_count", id),  int'(word_count),    int'(v.e_wc));
    endtask

    initial begin
        int b_fs, b_fe, b_ls, b_le, b_ecc, b_crc, b_tr, b_done, b_first, b_last, b_pix;

        //            fs fe ls le ecc crc tr done npix last lc   dt     wc
        tbl[0]  = with_exp(hdr_vec(8'h00, 16'h0000, 8'h00),
                           1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'h00, 16'h0000);
        tbl[1]  = long_vec(8'h2A, 16'd4, 8'h11);
        tbl[1].gaps = 1'b1;
        tbl[1]  = with_exp(tbl[1], 0, 0, 0, 0, 0, 0, 0, 1, 4, 1, 1, 6'h2A, 16'd4);
        tbl[2]  = with_exp(hdr_vec(8'h00, 16'h0000, 8'h00),
                           1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'h00, 16'h0000);
        tbl[3]  = long_vec(8'h2A, 16'd4, 8'h11);
        tbl[3].crc_xor = 16'h0001;
        tbl[3]  = with_exp(tbl[3], 0, 0, 0, 0, 0, 1, 0, 1, 4, 1, 1, 6'h2A, 16'd4);
        tbl[4]  = with_exp(hdr_vec(8'h01, 16'h0000, 8'h07),
                           0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 6'h2A, 16'd4);
        tbl[5]  = with_exp(hdr_vec(8'h01, 16'h0000, 8'h00),
                           0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 6'h01, 16'h0000);
        tbl[6]  = long_vec(8'h2A, 16'd8, 8'h11);
        tbl[6].trunc  = 1'b1;
        tbl[6].ntrunc = 3;
        tbl[6]  = with_exp(tbl[6], 0, 0, 0, 0, 0, 0, 1, 0, 3, 0, 1, 6'h2A, 16'd8);
        tbl[7]  = with_exp(hdr_vec(8'h00, 16'h0000, 8'h00),
                           1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'h00, 16'h0000);
        tbl[8]  = long_vec(8'h2B, 16'd2, 8'h11);
        tbl[8].gaps = 1'b1;
        tbl[8]  = with_exp(tbl[8], 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 6'h2B, 16'd2);
        tbl[9]  = with_exp(hdr_vec(8'h2A, 16'd4097, 8'h00),
                           0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 6'h2B, 16'd2);
        tbl[10] = with_exp(hdr_vec(8'h42, 16'h0000, 8'h00),
                           0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 6'h02, 16'h0000);
        tbl[11] = with_exp(hdr_vec(8'h03, 16'h0000, 8'h00),
                           0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 6'h03, 16'h0000);
        tbl[12] = with_exp(hdr_vec(8'h08, 16'h1234, 8'h00),
                           0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'h08, 16'h1234);
        tbl[13] = with_exp(long_vec(8'h2A, 16'd1, 8'h5A),
                           0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 6'h2A, 16'd1);
        tbl[14] = with_exp(long_vec(8'h2A, 16'd0, 8'h00),
                           0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2, 6'h2A, 16'd0);
        tbl[15] = with_exp(hdr_vec(8'h00, 16'h0000, 8'h40),
                           0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 2, 6'h2A, 16'd0);
        tbl[16] = long_vec(8'h2A, 16'd24, 8'h00);
        tbl[16].known      = 1'b1;
        tbl[16].crc_lit_en = 1'b1;
        tbl[16].crc_lit    = 16'h00F0;
        tbl[16] = with_exp(tbl[16], 0, 0, 0, 0, 0, 0, 0, 1, 24, 1, 3, 6'h2A, 16'd24);
        tbl[17] = with_exp(long_vec(8'h2A, 16'd4096, 8'h01),
                           0, 0, 0, 0, 0, 0, 0, 1, 4096, 1, 4, 6'h2A, 16'd4096);

        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        bus.in_sot   = 1'b0;
        bus.in_eot   = 1'b0;
        reset        = 1'b0;
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        check_val("reset.pix_valid",   int'(bus.pix_valid), 0);
        check_val("reset.frame_start", int'(frame_start),   0);
        check_val("reset.ecc_err",     int'(ecc_err),       0);
        check_val("reset.packet_done", int'(packet_done),   0);
        check_val("reset.data_type",   int'(data_type),     0);
        check_val("reset.word_count",  int'(word_count),    0);
        check_val("reset.line_count",  int'(line_count),    0);
        reset = 1'b1;
        idle_cycles(2);

        // Stray byte and eot in IDLE must be ignored.
        send_byte(8'h55, 1'b0, 1'b0, 1'b0);
        send_eot();
        idle_cycles(2);
        check_val("idle.ignored_trunc", cnt_trunc, 0);
        check_val("idle.ignored_ecc",   cnt_ecc,   0);

        for (int i = 0; i < NVEC; i++) begin
            b_fs = cnt_fs;   b_fe = cnt_fe;   b_ls = cnt_ls;     b_le = cnt_le;
            b_ecc = cnt_ecc; b_crc = cnt_crc; b_tr = cnt_trunc;  b_done = cnt_done;
            b_first = cnt_first; b_last = cnt_last; b_pix = pix_q.size();
            apply_stimulus(tbl[i]);
            check_output(i, tbl[i], b_fs, b_fe, b_ls, b_le, b_ecc, b_crc, b_tr, b_done,
                         b_first, b_last, b_pix);
        end

        // FS pulse lands exactly one cycle after the 4th header byte.
        send_byte(8'h00, 1'b1, 1'b0, 1'b0);
        send_byte(8'h00, 1'b0, 1'b0, 1'b0);
        send_byte(8'h00, 1'b0, 1'b0, 1'b0);
        check_val("seq_fs.early", int'(frame_start), 0);
        send_byte(8'h00, 1'b0, 1'b0, 1'b0);
        @(negedge sys_clk);
        check_val("seq_fs.pulse",      int'(frame_start), 1);
        check_val("seq_fs.line_count", int'(line_count),  0);
        check_val("seq_fs.ecc_err",    int'(ecc_err),     0);
        @(negedge sys_clk);
        check_val("seq_fs.width",      int'(frame_start), 0);
        #1;

        // WC=1 selected packet: pix one cycle after the byte, first and last
        // together; in_eot on the final CRC byte still completes cleanly.
        send_header(8'h2A, 16'd1, 8'h00, 1'b0);
        send_byte(8'h77, 1'b0, 1'b0, 1'b0);
        @(negedge sys_clk);
        check_val("seq_w1.pix_valid", int'(bus.pix_valid), 1);
        check_val("seq_w1.pix_data",  int'(bus.pix_data),  8'h77);
        check_val("seq_w1.pix_first", int'(bus.pix_first), 1);
        check_val("seq_w1.pix_last",  int'(bus.pix_last),  1);
        #1;
        begin
            logic [15:0] c;
            c = crc_model(16'hFFFF, 8'h77);
            send_byte(c[7:0],  1'b0, 1'b0, 1'b0);
            send_byte(c[15:8], 1'b0, 1'b1, 1'b0);
        end
        @(negedge sys_clk);
        check_val("seq_w1.packet_done", int'(packet_done), 1);
        check_val("seq_w1.crc_err",     int'(crc_err),     0);
        check_val("seq_w1.trunc_err",   int'(trunc_err),   0);
        check_val("seq_w1.line_count",  int'(line_count),  1);
        #1;
        idle_cycles(2);

        // Early sot during payload aborts and starts a new (FS) header.
        b_tr = cnt_trunc; b_fs = cnt_fs; b_done = cnt_done;
        b_last = cnt_last; b_pix = pix_q.size();
        send_header(8'h2A, 16'd4, 8'h00, 1'b0);
        send_byte(8'hA1, 1'b0, 1'b0, 1'b0);
        send_byte(8'hA2, 1'b0, 1'b0, 1'b0);
        send_header(8'h00, 16'h0000, 8'h00, 1'b0);
        idle_cycles(3);
        check_val("seq_sot.trunc_err",   cnt_trunc - b_tr,      1);
        check_val("seq_sot.frame_start", cnt_fs - b_fs,         1);
        check_val("seq_sot.packet_done", cnt_done - b_done,     0);
        check_val("seq_sot.pix_count",   pix_q.size() - b_pix,  2);
        check_val("seq_sot.pix_last",    cnt_last - b_last,     0);
        check_val("seq_sot.line_count",  int'(line_count),      0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
